cp0_irq_ctrl: RTL and testbench

- Coprocessor-0 block for the pipelined MIPS core. It is the consumer of the timer's IRQ output and of the other external interrupt lines.
- It samples hardware interrupts and holds the SR, Cause, EPC and PRId registers. It serves mtc0/mfc0 and eret.
- It decides in the M stage whether the pipeline must flush and jump to the handler.
- It sits beside the M stage. The system bridge routes the TC IRQ lines into hw_int.

---
 rtl/cp0_pkg.sv | 33 +++
 rtl/cp0_irq_ctrl.sv | 110 +++++++++++
 tb/tb_cp0_irq_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/cp0_pkg.sv
// Coprocessor-0 shared definitions: register numbers, exception codes and
// SR/Cause field positions.
package cp0_pkg;

  localparam int HW_INT_W = 6;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // SR field positions
  localparam int SR_IE     = 0;
  localparam int SR_EXL    = 1;
  localparam int SR_IM_LO  = 10;
  localparam int SR_IM_HI  = 15;

  // Cause field positions
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_BD     = 31;

  localparam logic [31:0] EPC_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/cp0_irq_ctrl.sv
// Coprocessor-0: SR/Cause/EPC/PRId registers, mtc0/mfc0/eret handling and the
// M-stage flush/redirect decision for interrupts and synchronous exceptions.
module cp0_irq_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] PRID         = 32'h2021_0007
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [HW_INT_W-1:0] hw_int,
  input  logic [31:0]         pc_m,
  input  logic                bd_m,
  input  logic [4:0]          exc_code_m,
  input  logic                mtc0_we,
  input  logic [4:0]          cp0_addr,
  input  logic [31:0]         cp0_wdata,
  output logic [31:0]         cp0_rdata,
  input  logic                eret_m,
  output logic                req,
  output logic [31:0]         handler_pc,
  output logic [31:0]         epc_out
);

  logic [HW_INT_W-1:0] sr_im;
  logic                sr_exl;
  logic                sr_ie;
  logic                cause_bd;
  logic [HW_INT_W-1:0] cause_ip;
  logic [4:0]          cause_exc;
  logic [31:0]         epc;

  logic        int_req;
  logic        exc_req;
  logic [31:0] sr_word;
  logic [31:0] cause_word;
  logic [31:0] epc_next;

  assign int_req = sr_ie & ~sr_exl & (|(sr_im & hw_int));
  assign exc_req = (exc_code_m != EXC_INT) & ~sr_exl;
  assign req     = int_req | exc_req;

  assign handler_pc = HANDLER_ADDR;
  assign epc_out    = epc;

  // Restart point: a delay-slot instruction resumes at its branch
  assign epc_next = (bd_m ? (pc_m - 32'd4) : pc_m) & EPC_MASK;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= EXC_INT;
      epc       <= '0;
    end else begin
      cause_ip <= hw_int;
      if (req) begin
        // The flushed instruction never commits, so its mtc0/eret is dropped
        sr_exl    <= 1'b1;
        cause_bd  <= bd_m;
        cause_exc <= int_req ? EXC_INT : exc_code_m;
        epc       <= epc_next;
      end else begin
        if (mtc0_we) begin
          unique case (cp0_addr)
            CP0_SR: begin
              sr_im  <= cp0_wdata[SR_IM_HI:SR_IM_LO];
              sr_exl <= cp0_wdata[SR_EXL];
              sr_ie  <= cp0_wdata[SR_IE];
            end
            CP0_EPC: epc <= cp0_wdata & EPC_MASK;
            default: ;
          endcase
        end
        if (eret_m) begin
          sr_exl <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    sr_word = '0;
    sr_word[SR_IM_HI:SR_IM_LO] = sr_im;
    sr_word[SR_EXL]            = sr_exl;
    sr_word[SR_IE]             = sr_ie;
  end

  always_comb begin
    cause_word = '0;
    cause_word[CAUSE_BD]                    = cause_bd;
    cause_word[CAUSE_IP_HI:CAUSE_IP_LO]     = cause_ip;
    cause_word[CAUSE_EXC_HI:CAUSE_EXC_LO]   = cause_exc;
  end

  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      CP0_SR:    cp0_rdata = sr_word;
      CP0_CAUSE: cp0_rdata = cause_word;
      CP0_EPC:   cp0_rdata = epc;
      CP0_PRID:  cp0_rdata = PRID;
      default:   cp0_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Directed scoreboard bench for cp0_irq_ctrl: stimulus queues expected values,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_cp0_irq_ctrl;

  localparam int K_RDATA = 0;
  localparam int K_REQ   = 1;
  localparam int K_EPC   = 2;
  localparam int K_HPC   = 3;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } sb_entry_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  hw_int;
  logic [31:0] pc_m;
  logic        bd_m;
  logic [4:0]  exc_code_m;
  logic        mtc0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic        eret_m;
  logic        req;
  logic [31:0] handler_pc;
  logic [31:0] epc_out;

  sb_entry_t sb[$];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cp0_irq_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .hw_int     (hw_int),
    .pc_m       (pc_m),
    .bd_m       (bd_m),
    .exc_code_m (exc_code_m),
    .mtc0_we    (mtc0_we),
    .cp0_addr   (cp0_addr),
    .cp0_wdata  (cp0_wdata),
    .cp0_rdata  (cp0_rdata),
    .eret_m     (eret_m),
    .req        (req),
    .handler_pc (handler_pc),
    .epc_out    (epc_out)
  );

  // Monitor: outputs are sampled mid-cycle, after the stimulus has settled
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      sb_entry_t e;
      logic [31:0] act;
      e = sb.pop_front();
      case (e.kind)
        K_RDATA: act = cp0_rdata;
        K_REQ:   act = {31'b0, req};
        K_EPC:   act = epc_out;
        default: act = handler_pc;
      endcase
      n_checks++;
      if (act !== e.exp) begin
        n_errors++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string n, input int k, input logic [31:0] e);
    sb_entry_t x;
    x.name = n;
    x.kind = k;
    x.exp  = e;
    sb.push_back(x);
  endtask

  task automatic exp_rd(input string n, input logic [4:0] a, input logic [31:0] e);
    cp0_addr = a;
    push(n, K_RDATA, e);
  endtask

  task automatic exp_req(input string n, input logic e);
    push(n, K_REQ, {31'b0, e});
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    mtc0_we   = 1'b1;
    cp0_addr  = a;
    cp0_wdata = d;
  endtask

  task automatic idle();
    mtc0_we    = 1'b0;
    eret_m     = 1'b0;
    exc_code_m = 5'd0;
    bd_m       = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    hw_int = '0; pc_m = 32'h0000_3000; bd_m = 1'b0; exc_code_m = '0;
    mtc0_we = 1'b0; cp0_addr = '0; cp0_wdata = '0; eret_m = 1'b0;
    repeat (3) nxt();
    reset = 1'b0;

    // Reset state
    exp_rd("rst_sr", 5'd12, 32'h0); exp_req("rst_req", 1'b0); push("rst_epc_out", K_EPC, 32'h0);
    push("handler_pc", K_HPC, 32'h0000_4180);
    nxt(); exp_rd("rst_cause", 5'd13, 32'h0);
    nxt(); exp_rd("rst_epc", 5'd14, 32'h0);
    nxt(); exp_rd("rst_prid", 5'd15, 32'h2021_0007);

    // Interrupt taken; mfc0 in the mtc0 cycle sees the old SR
    nxt(); mtc0(5'd12, 32'h0000_0401); exp_rd("mtc0_old_sr", 5'd12, 32'h0); exp_req("mtc0_no_req", 1'b0);
    nxt(); idle(); hw_int = 6'b000001; pc_m = 32'h3010;
    exp_req("int_req", 1'b1); exp_rd("int_sr_before", 5'd12, 32'h0000_0401);
    nxt(); exp_req("int_req_after", 1'b0); exp_rd("int_sr", 5'd12, 32'h0000_0403);
    nxt(); exp_rd("int_cause", 5'd13, 32'h0000_0400);
    nxt(); exp_rd("int_epc", 5'd14, 32'h3010); push("int_epc_out", K_EPC, 32'h3010);

    // eret with the line still asserted
    nxt(); eret_m = 1'b1; exp_req("eret_req", 1'b0); push("eret_epc_out", K_EPC, 32'h3010);
    nxt(); eret_m = 1'b0; exp_req("post_eret_req", 1'b1); exp_rd("post_eret_sr", 5'd12, 32'h0000_0401);
    nxt(); hw_int = '0; exp_req("retaken_req", 1'b0); exp_rd("retaken_sr", 5'd12, 32'h0000_0403);

    // Overflow in a delay slot
    nxt(); eret_m = 1'b1;
    nxt(); eret_m = 1'b0; exc_code_m = 5'd12; bd_m = 1'b1; pc_m = 32'h3024; exp_req("exc_req", 1'b1);
    nxt(); idle(); exp_req("exc_req_after", 1'b0); exp_rd("bd_epc", 5'd14, 32'h3020);
    nxt(); exp_rd("bd_cause", 5'd13, 32'h8000_0030);
    nxt(); exc_code_m = 5'd10; exp_req("exc_under_exl", 1'b0);

    // Interrupt beats a simultaneous exception
    nxt(); idle(); eret_m = 1'b1;
    nxt(); eret_m = 1'b0; hw_int = 6'b000001; exc_code_m = 5'd4; pc_m = 32'h3030; exp_req("prio_req", 1'b1);
    nxt(); idle(); exp_rd("prio_cause", 5'd13, 32'h0000_0400);
    nxt(); exp_rd("prio_epc", 5'd14, 32'h3030);

    // mtc0 EPC discarded when req fires in the same cycle
    nxt(); eret_m = 1'b1;
    nxt(); eret_m = 1'b0; pc_m = 32'h3040; mtc0(5'd14, 32'h5000); exp_req("coll_req", 1'b1);
    nxt(); idle(); exp_rd("coll_epc", 5'd14, 32'h3040);
    nxt(); exp_rd("coll_sr", 5'd12, 32'h0000_0403);

    // EPC write clears the low bits
    nxt(); mtc0(5'd14, 32'h5003); exp_req("epc_wr_req", 1'b0);
    nxt(); idle(); exp_rd("epc_wr", 5'd14, 32'h5000); push("epc_wr_out", K_EPC, 32'h5000);

    // Masked lines, read-only Cause, unmapped register
    nxt(); mtc0(5'd12, 32'h0000_0001);
    nxt(); idle(); hw_int = 6'b111111; exp_req("masked_req", 1'b0); exp_rd("masked_sr", 5'd12, 32'h0000_0001);
    nxt(); mtc0(5'd13, 32'hFFFF_FFFF); exp_rd("masked_cause", 5'd13, 32'h0000_FC00);
    nxt(); idle(); exp_rd("cause_ro", 5'd13, 32'h0000_FC00);
    nxt(); exp_rd("unmapped", 5'd5, 32'h0);

    // New IM applies only from the next cycle
    nxt(); mtc0(5'd12, 32'h0000_0801); exp_req("im_same_cycle", 1'b0);
    nxt(); idle(); pc_m = 32'h3050; exp_req("im_next_cycle", 1'b1);
    nxt(); hw_int = '0; exp_rd("im_taken_sr", 5'd12, 32'h0000_0803);

    // SR write mask
    nxt(); mtc0(5'd12, 32'hFFFF_FFFF);
    nxt(); idle(); exp_rd("sr_mask", 5'd12, 32'h0000_FC03);

    // Reset mid-handler
    nxt(); reset = 1'b1;
    nxt(); reset = 1'b0; hw_int = 6'b000001; exp_rd("rst2_sr", 5'd12, 32'h0); exp_req("rst2_req", 1'b0);
    nxt(); exp_rd("rst2_epc", 5'd14, 32'h0);
    nxt();

    for (int i = 0; i < 10 && sb.size() > 0; i++) nxt();
    if (sb.size() > 0) begin
      n_errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
